// File: rtl/branch_predictor_if.sv
// Fetch/resolver-facing bus of the branch predictor: lookup request, registered
// prediction, and resolution update.
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic            lookup_valid;
    logic [XLEN-1:0] lookup_pc;
    logic            pred_valid;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;

    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_valid, pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output pred_valid, pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch direction predictor / target buffer with 2-bit counters.
// Define BP_BYPASS_EN to forward a same-cycle matching update into the lookup.
module branch_predictor #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = XLEN - INDEX_BITS - 2
) (
    input logic               clock,
    input logic               reset,
    branch_predictor_if.slave bp
);
    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic            pred_valid_q;
    logic            pred_hit_q;
    logic            pred_taken_q;
    logic [XLEN-1:0] pred_target_q;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [TAG_BITS-1:0]   up_tag;

    logic            up_hit;
    logic            upd_we;
    logic [XLEN-1:0] ent_target_d;
    logic [1:0]      ent_ctr_d;

    logic            rd_hit;
    logic [1:0]      rd_ctr;
    logic [XLEN-1:0] rd_target;

    logic unused_pc_bits;

    assign lk_idx = bp.lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = bp.lookup_pc[XLEN-1:INDEX_BITS+2];
    assign up_idx = bp.upd_pc[INDEX_BITS+1:2];
    assign up_tag = bp.upd_pc[XLEN-1:INDEX_BITS+2];

    assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

    // Next state of the entry addressed by the update port.
    always_comb begin
        upd_we       = 1'b0;
        ent_target_d = target_q[up_idx];
        ent_ctr_d    = ctr_q[up_idx];
        up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (bp.upd_valid) begin
            if (up_hit) begin
                upd_we = 1'b1;
                if (bp.upd_taken) begin
                    ent_ctr_d    = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
                    ent_target_d = bp.upd_target;
                end else begin
                    ent_ctr_d = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                upd_we       = 1'b1;
                ent_ctr_d    = 2'd2;
                ent_target_d = bp.upd_target;
            end
        end
    end

    // Lookup read; pre-update contents unless forwarding is built in.
    always_comb begin
        rd_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        rd_ctr    = ctr_q[lk_idx];
        rd_target = target_q[lk_idx];
`ifdef BP_BYPASS_EN
        if (upd_we && (up_idx == lk_idx) && (up_tag == lk_tag)) begin
            rd_hit    = 1'b1;
            rd_ctr    = ent_ctr_d;
            rd_target = ent_target_d;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= bp.lookup_valid;
            pred_hit_q    <= bp.lookup_valid && rd_hit;
            pred_taken_q  <= bp.lookup_valid && rd_hit && rd_ctr[1];
            pred_target_q <= (bp.lookup_valid && rd_hit) ? rd_target : '0;
            if (upd_we) begin
                valid_q[up_idx] <= 1'b1;
            end
        end
    end

    // Payload arrays carry no reset; only the valid bits gate their use.
    always_ff @(posedge clock) begin
        if (reset && upd_we) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= ent_target_d;
            ctr_q[up_idx]    <= ent_ctr_d;
        end
    end

    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_hit    = pred_hit_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_target = pred_target_q;

endmodule
